// File: rtl/online_div_pkg.sv
// online_div_pkg
//   Shared definitions for the online divider's residue store.
//   - ADDR_WIDTH_DEF / UNROLLING_DEF / SHIFT_DEF: default geometry.
//   - sd_digit_t: one signed digit, held as a plus bit and a minus bit.
//   - op_e: the store operation, either LOAD or SHIFT.
//   - canon_digit(): maps the redundant (1,1) digit onto (0,0).
package online_div_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 7;
  localparam int unsigned UNROLLING_DEF  = 64;
  localparam int unsigned SHIFT_DEF      = 2;

  typedef struct packed {
    logic plus;
    logic minus;
  } sd_digit_t;

  typedef enum logic {
    OP_SHIFT = 1'b0,
    OP_LOAD  = 1'b1
  } op_e;

  // Both (1,1) and (0,0) encode a zero digit; only (0,0) is ever stored.
  function automatic sd_digit_t canon_digit(sd_digit_t d);
    sd_digit_t r;
    r.plus  = d.plus & ~d.minus;
    r.minus = d.minus & ~d.plus;
    return r;
  endfunction

endpackage

// File: rtl/online_residue_line_update.sv
// online_residue_line_update
//   Combinational next-value logic for one residue line.
//   Ports:
//     op              in   LOAD or SHIFT (op_e encoding)
//     old_plus/minus  in   current line contents
//     v_plus/minus    in   LOAD data
//     shift_in_*      in   digits that enter at the LSB end on SHIFT
//     new_plus/minus  out  canonical line to be written back
//     shift_out_*     out  top SHIFT digits of the old line (0 for LOAD)
module online_residue_line_update
  import online_div_pkg::*;
#(
  parameter int unsigned UNROLLING = UNROLLING_DEF,
  parameter int unsigned SHIFT     = SHIFT_DEF
) (
  input  logic                 op,
  input  logic [UNROLLING-1:0] old_plus,
  input  logic [UNROLLING-1:0] old_minus,
  input  logic [UNROLLING-1:0] v_plus,
  input  logic [UNROLLING-1:0] v_minus,
  input  logic [SHIFT-1:0]     shift_in_plus,
  input  logic [SHIFT-1:0]     shift_in_minus,
  output logic [UNROLLING-1:0] new_plus,
  output logic [UNROLLING-1:0] new_minus,
  output logic [SHIFT-1:0]     shift_out_plus,
  output logic [SHIFT-1:0]     shift_out_minus
);

  logic [UNROLLING-1:0] raw_plus;
  logic [UNROLLING-1:0] raw_minus;
  sd_digit_t            dig;

  always_comb begin
    raw_plus        = '0;
    raw_minus       = '0;
    shift_out_plus  = '0;
    shift_out_minus = '0;
    if (op_e'(op) == OP_LOAD) begin
      raw_plus  = v_plus;
      raw_minus = v_minus;
    end else begin
      raw_plus        = {old_plus[UNROLLING-1-SHIFT:0], shift_in_plus};
      raw_minus       = {old_minus[UNROLLING-1-SHIFT:0], shift_in_minus};
      shift_out_plus  = old_plus[UNROLLING-1 -: SHIFT];
      shift_out_minus = old_minus[UNROLLING-1 -: SHIFT];
    end
  end

  always_comb begin
    new_plus  = '0;
    new_minus = '0;
    dig       = '0;
    for (int unsigned i = 0; i < UNROLLING; i++) begin
      dig          = canon_digit(sd_digit_t'{plus: raw_plus[i], minus: raw_minus[i]});
      new_plus[i]  = dig.plus;
      new_minus[i] = dig.minus;
    end
  end

endmodule

// File: rtl/v_frac_residue_store.sv
// v_frac_residue_store
//   Per-line store of the divider's fractional V digits in signed-digit
//   form. Each op either loads a line or shifts it left by SHIFT digits,
//   returning the digits shifted out. Two-edge latency, one op per cycle.
//   Ports:
//     clk, asyn_reset          clock, async active-high reset
//     enable, new_line, addr   op request (new_line=1 LOAD, 0 SHIFT)
//     v_plus/minus_frac        LOAD data
//     shift_in_plus/minus      SHIFT fill digits
//     w_plus/minus_frac        resulting line
//     shift_out_plus/minus     digits shifted out (0 for LOAD)
//     out_valid                one-cycle pulse per completed op
module v_frac_residue_store
  import online_div_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned UNROLLING  = UNROLLING_DEF,
  parameter int unsigned SHIFT      = SHIFT_DEF
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic                  enable,
  input  logic                  new_line,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [UNROLLING-1:0]  v_plus_frac,
  input  logic [UNROLLING-1:0]  v_minus_frac,
  input  logic [SHIFT-1:0]      shift_in_plus,
  input  logic [SHIFT-1:0]      shift_in_minus,
  output logic [UNROLLING-1:0]  w_plus_frac,
  output logic [UNROLLING-1:0]  w_minus_frac,
  output logic [SHIFT-1:0]      shift_out_plus,
  output logic [SHIFT-1:0]      shift_out_minus,
  output logic                  out_valid
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [UNROLLING-1:0] mem_plus  [DEPTH];
  logic [UNROLLING-1:0] mem_minus [DEPTH];

  logic                  s1_valid;
  op_e                   s1_op;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [UNROLLING-1:0]  s1_v_plus;
  logic [UNROLLING-1:0]  s1_v_minus;
  logic [SHIFT-1:0]      s1_sin_plus;
  logic [SHIFT-1:0]      s1_sin_minus;
  logic [UNROLLING-1:0]  s1_old_plus;
  logic [UNROLLING-1:0]  s1_old_minus;

  logic [UNROLLING-1:0]  upd_plus;
  logic [UNROLLING-1:0]  upd_minus;
  logic [SHIFT-1:0]      upd_so_plus;
  logic [SHIFT-1:0]      upd_so_minus;
  logic                  fwd;

  online_residue_line_update #(
    .UNROLLING (UNROLLING),
    .SHIFT     (SHIFT)
  ) u_update (
    .op              (s1_op),
    .old_plus        (s1_old_plus),
    .old_minus       (s1_old_minus),
    .v_plus          (s1_v_plus),
    .v_minus         (s1_v_minus),
    .shift_in_plus   (s1_sin_plus),
    .shift_in_minus  (s1_sin_minus),
    .new_plus        (upd_plus),
    .new_minus       (upd_minus),
    .shift_out_plus  (upd_so_plus),
    .shift_out_minus (upd_so_minus)
  );

  // The RAM write of S1 lands on the same edge as this read, so a
  // same-line request must take S1's result instead of the stale line.
  assign fwd = s1_valid && (s1_addr == addr);

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      s1_valid     <= 1'b0;
      s1_op        <= OP_SHIFT;
      s1_addr      <= '0;
      s1_v_plus    <= '0;
      s1_v_minus   <= '0;
      s1_sin_plus  <= '0;
      s1_sin_minus <= '0;
      s1_old_plus  <= '0;
      s1_old_minus <= '0;
    end else begin
      s1_valid <= enable;
      if (enable) begin
        s1_op        <= new_line ? OP_LOAD : OP_SHIFT;
        s1_addr      <= addr;
        s1_v_plus    <= v_plus_frac;
        s1_v_minus   <= v_minus_frac;
        s1_sin_plus  <= shift_in_plus;
        s1_sin_minus <= shift_in_minus;
        s1_old_plus  <= fwd ? upd_plus  : mem_plus[addr];
        s1_old_minus <= fwd ? upd_minus : mem_minus[addr];
      end
    end
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_plus[i]  <= '0;
        mem_minus[i] <= '0;
      end
    end else if (s1_valid) begin
      mem_plus[s1_addr]  <= upd_plus;
      mem_minus[s1_addr] <= upd_minus;
    end
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      w_plus_frac     <= '0;
      w_minus_frac    <= '0;
      shift_out_plus  <= '0;
      shift_out_minus <= '0;
      out_valid       <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        w_plus_frac     <= upd_plus;
        w_minus_frac    <= upd_minus;
        shift_out_plus  <= upd_so_plus;
        shift_out_minus <= upd_so_minus;
      end
    end
  end

endmodule
